// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared mode codes, pattern states and defaults for the bicolor LED driver
package led_pattern_pkg;
  localparam int PWM_BITS_DEF = 8;
  localparam logic [2:0] MODE_OFF = 3'd0;
  localparam logic [2:0] MODE_RED = 3'd1;
  localparam logic [2:0] MODE_GREEN = 3'd2;
  localparam logic [2:0] MODE_BLINK = 3'd3;
  localparam logic [2:0] MODE_FADE = 3'd4;
  typedef enum logic [2:0] {S_OFF, S_SOLID_R, S_SOLID_G, S_BLINK, S_FADE_UP, S_FADE_DN} state_e;
  function automatic state_e mode_to_state(input logic [2:0] m);
    return m == MODE_RED ? S_SOLID_R :
           m == MODE_GREEN ? S_SOLID_G :
           m == MODE_BLINK ? S_BLINK :
           m == MODE_FADE ? S_FADE_UP : S_OFF;
  endfunction
endpackage

// File: rtl/bicolor_pwm_core.sv
// bicolor_pwm_core: frame counter, frame-boundary shadow duties and registered red/green PWM compare
module bicolor_pwm_core
  import led_pattern_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] r_next_i,
  input  logic [PWM_BITS-1:0] g_next_i,
  output logic                fb_o,
  output logic                red_led_o,
  output logic                green_led_o
);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [PWM_BITS:0] FULL = {1'b1, {PWM_BITS{1'b0}}};
  logic [PWM_BITS-1:0] cnt_q, r_sh_q, g_sh_q;
  logic red_q, green_q;
  assign fb_o = cnt_q == CNT_MAX;
  assign red_led_o = red_q;
  assign green_led_o = green_q;
  // Free-running counter; duties only change at the frame boundary; red leads the frame, green trails it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      r_sh_q <= '0;
      g_sh_q <= '0;
      red_q <= 1'b0;
      green_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + PWM_BITS'(1);
      if (fb_o) begin
        r_sh_q <= r_next_i;
        g_sh_q <= g_next_i;
      end
      red_q <= cnt_q < r_sh_q;
      green_q <= {1'b0, cnt_q} >= FULL - {1'b0, g_sh_q};
    end
  end
endmodule

// File: rtl/bicolor_led_pattern_pwm.sv
// bicolor_led_pattern_pwm: command handshake and solid/blink/crossfade sequencer feeding the PWM core
module bicolor_led_pattern_pwm
  import led_pattern_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int BLINK_FRAMES = 20,
  parameter int FADE_STEP_FRAMES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_mode,
  input  logic [PWM_BITS-1:0] cmd_level,
  output logic                busy,
  output logic                red_led,
  output logic                green_led
);
  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);
  state_e state_q, state_d;
  logic pend_q, phase_q, phase_d, fb, accept, apply;
  logic [2:0] pmode_q;
  logic [PWM_BITS-1:0] plevel_q, level_q, level_d, fpos_q, fpos_d, r_next, g_next;
  logic [15:0] fcnt_q, fcnt_d, fcnt_inc;
  assign cmd_ready = ~pend_q;
  assign accept = cmd_valid & cmd_ready;
  assign apply = fb & pend_q;
  assign busy = state_q != S_OFF;
  assign fcnt_inc = fcnt_q + 16'd1;
  // Hold one accepted command until the next frame boundary consumes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      pmode_q <= MODE_OFF;
      plevel_q <= '0;
    end else if (apply) begin
      pend_q <= 1'b0;
    end else if (accept) begin
      pend_q <= 1'b1;
      pmode_q <= cmd_mode;
      plevel_q <= cmd_level;
    end
  end
  // Pattern state register; phase 0 is red, fade direction is carried by the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      phase_q <= 1'b0;
      fpos_q <= '0;
      fcnt_q <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      fpos_q <= fpos_d;
      fcnt_q <= fcnt_d;
      level_q <= level_d;
    end
  end
  // Advance the pattern once per frame, or restart it from a newly applied command
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    fpos_d = fpos_q;
    fcnt_d = fcnt_q;
    level_d = level_q;
    if (apply) begin
      state_d = mode_to_state(pmode_q);
      level_d = plevel_q;
      phase_d = 1'b0;
      fpos_d = '0;
      fcnt_d = '0;
    end else if (fb) begin
      fcnt_d = fcnt_inc;
      if (state_q == S_BLINK && fcnt_inc == 16'(BLINK_FRAMES)) begin
        phase_d = ~phase_q;
        fcnt_d = '0;
      end
      if (state_q == S_FADE_UP && fcnt_inc == 16'(FADE_STEP_FRAMES)) begin
        fcnt_d = '0;
        state_d = fpos_q == LVL_MAX ? S_FADE_DN : S_FADE_UP;
        fpos_d = fpos_q == LVL_MAX ? fpos_q - ONE : fpos_q + ONE;
      end
      if (state_q == S_FADE_DN && fcnt_inc == 16'(FADE_STEP_FRAMES)) begin
        fcnt_d = '0;
        state_d = fpos_q == '0 ? S_FADE_UP : S_FADE_DN;
        fpos_d = fpos_q == '0 ? fpos_q + ONE : fpos_q - ONE;
      end
    end
  end
  // Duties from the post-update pattern so a new command lands in the same frame-boundary load
  always_comb begin
    r_next = '0;
    g_next = '0;
    if (state_d == S_SOLID_R || (state_d == S_BLINK && !phase_d)) r_next = level_d;
    if (state_d == S_SOLID_G || (state_d == S_BLINK && phase_d)) g_next = level_d;
    if (state_d == S_FADE_UP || state_d == S_FADE_DN) begin
      r_next = LVL_MAX - fpos_d;
      g_next = fpos_d;
    end
  end
  bicolor_pwm_core #(.PWM_BITS(PWM_BITS)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .r_next_i(r_next),
    .g_next_i(g_next),
    .fb_o(fb),
    .red_led_o(red_led),
    .green_led_o(green_led)
  );
endmodule
